// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Divider datapath is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod;
    logic [2*WIDTH-1:0] iter;

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    // Shift-add: accumulate the multiplicand into the upper half, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod     = neg_q ? -mul_next : mul_next;

`ifdef MULDIV_DIV_EN
    logic               sa_q, sa_d;
    logic [2*WIDTH:0]   div_shift;
    logic [WIDTH-1:0]   div_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo, rem, quo_s, rem_s;

    // Restoring division: {remainder, quotient} shifted left, trial subtract on the top.
    assign div_shift = {acc_q, 1'b0};
    assign div_ge    = div_shift[2*WIDTH:WIDTH] >= {1'b0, opb_q};
    assign div_trial = div_shift[2*WIDTH-1:WIDTH] - opb_q;
    assign div_next  = div_ge ? {div_trial, div_shift[WIDTH-1:1], 1'b1}
                              : div_shift[2*WIDTH-1:0];
    assign iter      = op_q[1] ? div_next : mul_next;

    assign quo   = div_next[WIDTH-1:0];
    assign rem   = div_next[2*WIDTH-1:WIDTH];
    // A zero divisor leaves rem = |a|, so signing it by a restores the raw dividend.
    assign quo_s = (opb_q == '0) ? '1 : (neg_q ? -quo : quo);
    assign rem_s = sa_q ? -rem : rem;
`else
    assign iter = mul_next;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        sa_d    = sa_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    state_d = S_RUN;
                    op_d    = op;
                    neg_d   = a_neg ^ b_neg;
                    opb_d   = b_abs;
                    acc_d   = {{WIDTH{1'b0}}, a_abs};
                    cnt_d   = '0;
`ifdef MULDIV_DIV_EN
                    sa_d    = a_neg;
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = iter;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    if (!op_q[1]) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
`ifdef MULDIV_DIV_EN
                    else begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            sa_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            sa_q    <= sa_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32), one task per scenario.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drives one issue cycle; called at a negedge, returns just after the issuing edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles after issue until done is seen (bounded); returns at that negedge.
    task automatic run_to_done(output int busy_cycles, output int done_cycle);
        busy_cycles = 0;
        done_cycle  = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin
                done_cycle = k;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] data);
        @(negedge clk);
        hi_we = whi; lo_we = wlo; wd = data;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %08h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %08h want 00000000", lo); end
        $display("reset: busy=%0b done=%0b hi=%08h lo=%08h", busy, done, hi, lo);
    endtask

    task automatic test_mult;
        int bc, dc;
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        run_to_done(bc, dc);
        checks++; if (bc !== 32) begin errors++; $display("FAIL mult_busy_cycles got %0d want 32", bc); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL mult_done_cycle got %0d want 33", dc); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %08h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %08h want fffffffa", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %0b want 0", done); end
        $display("MULT fffffffe*3: done@%0d hi=%08h lo=%08h", dc, hi, lo);
    endtask

    task automatic test_back_to_back;
        int bc, dc;
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_to_done(bc, dc);
        checks++; if (dc !== 33) begin errors++; $display("FAIL multu_done_cycle got %0d want 33", dc); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %08h want 00000002", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %08h want fffffffa", lo); end
        $display("MULTU fffffffe*3: done@%0d hi=%08h lo=%08h", dc, hi, lo);
        issue(OP_MULTU, 32'd5, 32'd7);
        run_to_done(bc, dc);
        checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_done_cycle got %0d want 33", dc); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 32", bc); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL b2b_hi got %08h want 00000000", hi); end
        checks++; if (lo !== 32'd35) begin errors++; $display("FAIL b2b_lo got %08h want 00000023", lo); end
        $display("MULTU 5*7 back-to-back: done@%0d hi=%08h lo=%08h", dc, hi, lo);
        @(negedge clk);
    endtask

    task automatic test_divide;
        int bc, dc;
        logic [31:0] exp_hi [3];
        logic [31:0] exp_lo [3];
        logic [1:0]  ops    [3];
        logic [31:0] as     [3];
        logic [31:0] bs     [3];
        ops[0] = OP_DIV;  as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;
        ops[1] = OP_DIVU; as[1] = 32'd100;       bs[1] = 32'd0;
        ops[2] = OP_DIV;  as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF;
`ifdef MULDIV_DIV_EN
        exp_lo[0] = 32'hFFFF_FFFD; exp_hi[0] = 32'hFFFF_FFFF;
        exp_lo[1] = 32'hFFFF_FFFF; exp_hi[1] = 32'h0000_0064;
        exp_lo[2] = 32'h8000_0000; exp_hi[2] = 32'h0000_0000;
`else
        for (int i = 0; i < 3; i++) begin
            exp_hi[i] = 32'hAAAA_5555;
            exp_lo[i] = 32'h5A5A_5A5A;
        end
`endif
        mt_write(1'b1, 1'b1, 32'hAAAA_5555);
        mt_write(1'b0, 1'b1, 32'h5A5A_5A5A);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            run_to_done(bc, dc);
            checks++; if (dc !== 33) begin errors++; $display("FAIL div%0d_done_cycle got %0d want 33", i, dc); end
            checks++; if (hi !== exp_hi[i]) begin errors++; $display("FAIL div%0d_hi got %08h want %08h", i, hi, exp_hi[i]); end
            checks++; if (lo !== exp_lo[i]) begin errors++; $display("FAIL div%0d_lo got %08h want %08h", i, lo, exp_lo[i]); end
            $display("DIV op=%0d a=%08h b=%08h: done@%0d hi=%08h lo=%08h", ops[i], as[i], bs[i], dc, hi, lo);
            @(negedge clk);
        end
    endtask

    task automatic test_mt_and_ignore;
        int dc;
        mt_write(1'b1, 1'b0, 32'h0000_1234);
        @(negedge clk);
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi got %08h want 00001234", hi); end
        $display("MTHI 1234: hi=%08h", hi);
        issue(OP_MULT, 32'd6, 32'hFFFF_FFF9);
        dc = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin dc = k; break; end
            if (k == 5) begin
                start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
                lo_we = 1'b1; wd = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; lo_we = 1'b0;
            end
        end
        checks++; if (dc !== 33) begin errors++; $display("FAIL ignore_done_cycle got %0d want 33", dc); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ignore_hi got %08h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFD6) begin errors++; $display("FAIL ignore_lo got %08h want ffffffd6", lo); end
        $display("MULT 6*-7 with mid-run start/lo_we: done@%0d hi=%08h lo=%08h", dc, hi, lo);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int seen;
        issue(OP_MULT, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset_hi got %08h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_lo got %08h want 00000000", lo); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", seen); end
        $display("reset at RUN cycle 10: busy=%0b hi=%08h lo=%08h done_pulses=%0d", busy, hi, lo, seen);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        @(negedge clk);
        test_reset;
        test_mult;
        test_back_to_back;
        test_divide;
        test_mt_and_ignore;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
